// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider producing Hi/Lo.
// Ports: clk, reset, start, op, rs_val, rt_val, read_hilo -> hi, lo, busy, done, div_by_zero, stall.
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             read_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sgn;
  logic [WIDTH:0]     sum, shl, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   qv, rv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rs_q    <= '0;
      b_q     <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      b_q     <= b_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs_d    = rs_q;
    b_d     = b_q;
    mq_d    = mq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    // op[1]: divide, op[0]: unsigned
    sgn  = ~op_q[0];
    sum  = acc_q + (mq_q[0] ? {1'b0, b_q} : '0);
    shl  = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    diff = shl - {1'b0, b_q};
    prod = {acc_q[WIDTH-1:0], mq_q};
    qv   = mq_q;
    rv   = acc_q[WIDTH-1:0];
    if (negq_q) begin
      prod = '0 - prod;
      qv   = '0 - qv;
    end
    if (negr_q) rv = '0 - rv;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          rs_d    = rs_val;
          mq_d    = rs_val;
          b_d     = rt_val;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (sgn && rs_q[WIDTH-1]) mq_d = '0 - rs_q;
        if (sgn && b_q[WIDTH-1])  b_d  = '0 - b_q;
        negq_d  = sgn & (rs_q[WIDTH-1] ^ b_q[WIDTH-1]);
        negr_d  = sgn & rs_q[WIDTH-1];
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (op_q[1]) begin
          // restoring step: keep the subtraction only if it stayed non-negative
          if (!diff[WIDTH]) begin
            acc_d = diff;
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shl;
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, sum[WIDTH:1]};
          mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        dbz_d = op_q[1] & (b_q == '0);
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
          hi_d = rs_q;
          lo_d = '1;
        end else begin
          hi_d = rv;
          lo_d = qv;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = done & dbz_q;
  assign stall       = (start | read_hilo) & busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases, busy/reset interactions
// and random operations against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] rs_val;
  logic [15:0] rt_val;
  logic        read_hilo;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        stall;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .read_hilo(read_hilo),
    .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [1:0] o,
                                input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] h, output logic [15:0] l,
                                output logic z);
    longint p;
    int x, y, q, r;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[31:16];
        l = p[15:0];
      end
      2'd1: begin
        p = longint'(a) * longint'(b);
        h = p[31:16];
        l = p[15:0];
      end
      default: begin
        if (b == 16'h0) begin
          h = a;
          l = 16'hFFFF;
          z = 1'b1;
        end else begin
          if (o == 2'd2) begin
            x = int'($signed(a));
            y = int'($signed(b));
          end else begin
            x = int'(a);
            y = int'(b);
          end
          q = x / y;
          r = x % y;
          h = r[15:0];
          l = q[15:0];
        end
      end
    endcase
  endfunction

  // Issues one op starting #1 after a posedge; returns #1 after the edge
  // that follows the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, output int lat,
                        output logic [15:0] h, output logic [15:0] l,
                        output logic z, output int bad, output logic bafter);
    logic [15:0] h0, l0;
    h0 = hi;
    l0 = lo;
    start = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    rs_val = 16'($urandom);
    rt_val = 16'($urandom);
    lat = -1;
    bad = 0;
    h = 'x;
    l = 'x;
    z = 'x;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        h = hi;
        l = lo;
        z = div_by_zero;
        break;
      end
      if (!busy || div_by_zero || hi !== h0 || lo !== l0) bad++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bafter = busy | done | div_by_zero;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    read_hilo = 1'b0;
    op = 2'd0;
    rs_val = '0;
    rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({hi, lo} !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
        div_by_zero !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dbz=%b stall=%b, required all 0",
               hi, lo, busy, done, div_by_zero, stall);
    end
    reset = 1'b0;
  endtask

  localparam logic [1:0]  VO [8] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
  localparam logic [15:0] VA [8] = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'hFFF9,
                                     16'h0064, 16'h0064, 16'h8000, 16'hFFF9};
  localparam logic [15:0] VB [8] = '{16'hFFFF, 16'h0005, 16'h8000, 16'h0002,
                                     16'h0007, 16'h0000, 16'hFFFF, 16'h0000};
  localparam logic [15:0] VH [8] = '{16'hFFFE, 16'hFFFF, 16'h4000, 16'hFFFF,
                                     16'h0002, 16'h0064, 16'h0000, 16'hFFF9};
  localparam logic [15:0] VL [8] = '{16'h0001, 16'hFFF1, 16'h0000, 16'hFFFD,
                                     16'h000E, 16'hFFFF, 16'h8000, 16'hFFFF};
  localparam logic        VZ [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic test_directed;
    int lat, bad;
    logic [15:0] h, l;
    logic z, ba;
    for (int i = 0; i < 8; i++) begin
      run_op(VO[i], VA[i], VB[i], lat, h, l, z, bad, ba);
      n_chk++;
      if (h !== VH[i] || l !== VL[i] || z !== VZ[i]) begin
        n_fail++;
        $display("FAIL directed_%0d result: hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
                 i, h, l, z, VH[i], VL[i], VZ[i]);
      end
      n_chk++;
      if (lat !== 18) begin
        n_fail++;
        $display("FAIL directed_%0d latency: %0d, required 18", i, lat);
      end
      n_chk++;
      if (bad !== 0 || ba !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_%0d busy_window: bad_cycles=%0d busy_after=%b, required 0/0",
                 i, bad, ba);
      end
      n_chk++;
      if (hi !== VH[i] || lo !== VL[i]) begin
        n_fail++;
        $display("FAIL directed_%0d hold: hi=%h lo=%h, required %h %h", i, hi, lo, VH[i], VL[i]);
      end
    end
  endtask

  task automatic test_busy;
    int lat, bad, held_bad;
    logic [15:0] h, l, ph, pl;
    logic z, ba;
    model(2'd1, 16'h1234, 16'h5678, ph, pl, z);
    run_op(2'd1, 16'h1234, 16'h5678, lat, h, l, z, bad, ba);
    n_chk++;
    if (hi !== ph || lo !== pl) begin
      n_fail++;
      $display("FAIL busy_preload: hi=%h lo=%h, required %h %h", hi, lo, ph, pl);
    end
    start = 1'b1;
    op = 2'd1;
    rs_val = 16'd2;
    rt_val = 16'd3;
    @(posedge clk);
    #1;
    lat = -1;
    held_bad = 0;
    for (int k = 0; k < 40; k++) begin
      start = 1'b0;
      read_hilo = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (k == 5) begin
        start = 1'b1;
        op = 2'd3;
        rs_val = 16'd9;
        rt_val = 16'd3;
        #1;
        n_chk++;
        if (stall !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_start_stall: stall=%b, required 1", stall);
        end
      end
      if (k == 10) begin
        read_hilo = 1'b1;
        #1;
        n_chk++;
        if (stall !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_read_stall: stall=%b, required 1", stall);
        end
      end
      if (hi !== ph || lo !== pl) held_bad++;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (lat !== 18 || hi !== 16'h0000 || lo !== 16'h0006 || held_bad !== 0) begin
      n_fail++;
      $display("FAIL busy_result: lat=%0d hi=%h lo=%h held_bad=%0d, required 18 0000 0006 0",
               lat, hi, lo, held_bad);
    end
    start = 1'b1;
    op = 2'd3;
    rs_val = 16'd9;
    rt_val = 16'd3;
    #1;
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL done_start_stall: stall=%b, required 1", stall);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || hi !== 16'h0000 || lo !== 16'h0006) begin
      n_fail++;
      $display("FAIL done_start_ignored: busy=%b hi=%h lo=%h, required 0 0000 0006",
               busy, hi, lo);
    end
    read_hilo = 1'b1;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_read_stall: stall=%b, required 0", stall);
    end
    @(posedge clk);
    #1;
    read_hilo = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || hi !== 16'h0000 || lo !== 16'h0006) begin
      n_fail++;
      $display("FAIL idle_read_side_effect: busy=%b hi=%h lo=%h, required 0 0000 0006",
               busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bad, pulses;
    logic [15:0] h, l;
    logic z, ba;
    start = 1'b1;
    op = 2'd1;
    rs_val = 16'h7777;
    rt_val = 16'h3333;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b, required 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 16'h0 || lo !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0000 0000",
               busy, done, hi, lo);
    end
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      if (done || busy) pulses++;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL mid_no_done: active_cycles=%0d, required 0", pulses);
    end
    run_op(2'd1, 16'd4, 16'd4, lat, h, l, z, bad, ba);
    n_chk++;
    if (lat !== 18 || h !== 16'h0000 || l !== 16'h0010 || z !== 1'b0 || bad !== 0) begin
      n_fail++;
      $display("FAIL mid_fresh_op: lat=%0d hi=%h lo=%h dbz=%b bad=%0d, required 18 0000 0010 0 0",
               lat, h, l, z, bad);
    end
  endtask

  task automatic test_random;
    int lat, bad;
    logic [15:0] a, b, h, l, eh, el;
    logic z, ez, ba;
    logic [1:0] o;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0000;
        1: b = 16'hFFFF;
        2: a = 16'h8000;
        3: begin a = 16'h8000; b = 16'hFFFF; end
        default: ;
      endcase
      model(o, a, b, eh, el, ez);
      run_op(o, a, b, lat, h, l, z, bad, ba);
      n_chk++;
      if (h !== eh || l !== el || z !== ez || lat !== 18 || bad !== 0 || ba !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d rs=%h rt=%h: hi=%h lo=%h dbz=%b lat=%0d bad=%0d ba=%b, required hi=%h lo=%h dbz=%b lat=18",
                 i, o, a, b, h, l, z, lat, bad, ba, eh, el, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
